// File: rtl/fios_result_collector_if.sv
// fios_result_collector_if
//   Handshake and result bundle between the end of a FIOS DSP cascade and the
//   top level. The master modport belongs to whoever drives the partial words
//   (the cascade or a bench). The slave modport belongs to the collector.
//   start_i    : begin a new collection
//   P_i        : partial word from the cascade, least-significant word first
//   P_valid_i  : P_i is valid this cycle
//   busy_o     : collecting
//   done_o     : one-cycle strobe, result_o complete
//   overflow_o : nonzero carry left after the last limb
//   result_o   : packed limbs, limb k at [WORD_WIDTH*k +: WORD_WIDTH]
interface fios_result_collector_if #(
    parameter int WORD_WIDTH = 17,
    parameter int WORD_COUNT = 8,
    parameter int P_WIDTH    = 34
);
    logic                             start_i;
    logic [P_WIDTH-1:0]               P_i;
    logic                             P_valid_i;
    logic                             busy_o;
    logic                             done_o;
    logic                             overflow_o;
    logic [WORD_COUNT*WORD_WIDTH-1:0] result_o;

    modport master (
        output start_i, P_i, P_valid_i,
        input  busy_o, done_o, overflow_o, result_o
    );

    modport slave (
        input  start_i, P_i, P_valid_i,
        output busy_o, done_o, overflow_o, result_o
    );
endinterface

// File: rtl/fios_result_collector.sv
// fios_result_collector
//   Reads the partial-word stream leaving the last DSP of a FIOS cascade. It
//   propagates the inter-word carry (word >> WORD_WIDTH) and rebuilds the final
//   product as packed WORD_WIDTH-bit limbs.
//   clock_i : system clock, rising edge
//   reset_i : synchronous, active-high reset
//   bus     : slave side of fios_result_collector_if (start / P / valid in,
//             busy / done / overflow / result out, all outputs registered)
module fios_result_collector #(
    parameter int WORD_WIDTH = 17,
    parameter int WORD_COUNT = 8,
    parameter int P_WIDTH    = 34
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    fios_result_collector_if.slave bus
);
    localparam int SUM_W   = P_WIDTH + 1;
    localparam int CARRY_W = SUM_W - WORD_WIDTH;
    localparam int RES_W   = WORD_COUNT * WORD_WIDTH;
    localparam int IDX_W   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, done_q;
    logic [SUM_W-1:0]   sum;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            carry_q    <= '0;
            index_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            index_q    <= index_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            // Status flags are decoded from the next state so that they line
            // up with the state they describe and remain pure flops.
            busy_q     <= (state_d == COLLECT);
            done_q     <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d    = state_q;
        carry_d    = carry_q;
        index_d    = index_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        sum        = {1'b0, bus.P_i} + SUM_W'(carry_q);

        case (state_q)
            IDLE: begin
                // P_valid_i is deliberately not looked at here, even with start_i.
                if (bus.start_i) begin
                    carry_d    = '0;
                    index_d    = '0;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.P_valid_i) begin
                    result_d[index_q*WORD_WIDTH +: WORD_WIDTH] = sum[WORD_WIDTH-1:0];
                    carry_d = sum[SUM_W-1:WORD_WIDTH];
                    if (index_q == LAST_IDX) begin
                        // Index parks on the last limb, so it never wraps.
                        overflow_d = |sum[SUM_W-1:WORD_WIDTH];
                        state_d    = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.overflow_o = overflow_q;
    assign bus.result_o   = result_q;
endmodule

// File: tb/tb_fios_result_collector.sv
// tb_fios_result_collector
//   Directed bench for fios_result_collector with WORD_COUNT=4. Inputs change
//   #1 after a rising edge, and outputs are read at that same point.
module tb_fios_result_collector;
    localparam int WW = 17;
    localparam int WC = 4;
    localparam int PW = 34;
    localparam int RW = WW * WC;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int   tests   = 0;
    int   fails   = 0;
    int   done_cnt = 0;

    fios_result_collector_if #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .P_WIDTH(PW)) bus ();

    fios_result_collector #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .P_WIDTH(PW)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clock_i = ~clock_i;

    always @(negedge clock_i) if (bus.done_o === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic send(input logic [PW-1:0] w);
        bus.P_valid_i = 1'b1;
        bus.P_i       = w;
        tick();
        bus.P_valid_i = 1'b0;
        bus.P_i       = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.start_i   = 1'($urandom);
            bus.P_valid_i = 1'($urandom);
            bus.P_i       = {2'($urandom), 32'($urandom)};
            tick();
        end
        reset_i = 1'b0;
        bus.start_i = 1'b0; bus.P_valid_i = 1'b0; bus.P_i = '0;
        tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.overflow_o); end
        tests++; if (bus.result_o !== '0) begin fails++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        tick();
    endtask

    task automatic test_basic();
        logic [RW-1:0] exp = {17'd11, 17'd9, 17'd7, 17'd5};
        int d0 = done_cnt;
        do_start();
        tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", bus.busy_o); end
        send(34'd5); send(34'd7); send(34'd9);
        tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL basic_early_done got %b want 0", bus.done_o); end
        send(34'd11);
        tests++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            fails++; $display("FAIL basic_done got done=%b busy=%b want done=1 busy=0", bus.done_o, bus.busy_o); end
        tests++; if (bus.result_o !== exp) begin fails++; $display("FAIL basic_result got %h want %h", bus.result_o, exp); end
        tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b want 0", bus.overflow_o); end
        tick();
        tests++; if (bus.done_o !== 1'b0 || done_cnt - d0 != 1) begin
            fails++; $display("FAIL basic_strobe got done=%b count=%0d want done=0 count=1", bus.done_o, done_cnt - d0); end
    endtask

    task automatic test_max();
        // sum0=0x3FFFFFFFF -> limb 0x1FFFF carry 0x1FFFF
        // sum1=0x40001FFFE -> limb 0x1FFFE carry 0x20000
        // sum2,3=0x40001FFFF -> limb 0x1FFFF carry 0x20000 (overflow)
        logic [RW-1:0] exp = {17'h1FFFF, 17'h1FFFF, 17'h1FFFE, 17'h1FFFF};
        do_start();
        for (int i = 0; i < 4; i++) send(34'h3FFFFFFFF);
        tests++; if (bus.result_o !== exp) begin fails++; $display("FAIL max_result got %h want %h", bus.result_o, exp); end
        tests++; if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL max_ovf got %b want 1", bus.overflow_o); end
        tick(); tick();
        tests++; if (bus.overflow_o !== 1'b1 || bus.result_o !== exp) begin
            fails++; $display("FAIL max_hold got ovf=%b res=%h want ovf=1 res=%h", bus.overflow_o, bus.result_o, exp); end
    endtask

    task automatic test_carry();
        logic [RW-1:0] exp = {17'd0, 17'd1, 17'd0, 17'd1};
        do_start();
        tests++; if (bus.result_o !== '0 || bus.overflow_o !== 1'b0) begin
            fails++; $display("FAIL start_clear got res=%h ovf=%b want 0/0", bus.result_o, bus.overflow_o); end
        send(34'h20001); send(34'h1FFFF); send(34'h0); send(34'h0);
        tests++; if (bus.result_o !== exp) begin fails++; $display("FAIL carry_result got %h want %h", bus.result_o, exp); end
        tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL carry_ovf got %b want 0", bus.overflow_o); end
        tick();
    endtask

    task automatic test_gaps();
        logic [RW-1:0] exp = {17'd11, 17'd9, 17'd7, 17'd5};
        int d0 = done_cnt;
        // valid word alongside start in IDLE must be dropped
        bus.P_valid_i = 1'b1; bus.P_i = 34'h1234;
        do_start();
        bus.P_valid_i = 1'b0; bus.P_i = '0;
        send(34'd5);
        tick();
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;   // start mid-collect, no valid
        send(34'd7);
        bus.start_i = 1'b1;
        send(34'd9);                                      // start alongside a word
        bus.start_i = 1'b0;
        tick(); tick(); tick();
        tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL gap_busy got %b want 1", bus.busy_o); end
        send(34'd11);
        tests++; if (bus.done_o !== 1'b1) begin fails++; $display("FAIL gap_done got %b want 1", bus.done_o); end
        tests++; if (bus.result_o !== exp) begin fails++; $display("FAIL gap_result got %h want %h", bus.result_o, exp); end
        // start and a valid word while in DONE: both ignored
        bus.start_i = 1'b1; bus.P_valid_i = 1'b1; bus.P_i = 34'd99;
        tick();
        bus.start_i = 1'b0; bus.P_valid_i = 1'b0; bus.P_i = '0;
        tick(); tick();
        tests++; if (bus.busy_o !== 1'b0 || done_cnt - d0 != 1) begin
            fails++; $display("FAIL gap_done_start got busy=%b count=%0d want busy=0 count=1", bus.busy_o, done_cnt - d0); end
        // valid word in IDLE: result untouched
        send(34'd77);
        tests++; if (bus.result_o !== exp || bus.busy_o !== 1'b0) begin
            fails++; $display("FAIL idle_valid got res=%h busy=%b want res=%h busy=0", bus.result_o, bus.busy_o, exp); end
    endtask

    task automatic test_reset_midop();
        logic [RW-1:0] exp = {17'd4, 17'd3, 17'd2, 17'd1};
        int d0 = done_cnt;
        do_start();
        send(34'd50); send(34'd60);
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        tests++; if (bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
            fails++; $display("FAIL midreset_clear got busy=%b res=%h want 0/0", bus.busy_o, bus.result_o); end
        tick();
        tests++; if (done_cnt != d0) begin fails++; $display("FAIL midreset_nodone got count=%0d want 0", done_cnt - d0); end
        do_start();
        send(34'd1); send(34'd2); send(34'd3); send(34'd4);
        tests++; if (bus.result_o !== exp) begin fails++; $display("FAIL midreset_result got %h want %h", bus.result_o, exp); end
        tick();
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL midreset_count got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.P_valid_i = 1'b0; bus.P_i = '0;
        test_reset();
        test_basic();
        test_max();
        test_carry();
        test_gaps();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
